// File: rtl/ft_req_if.sv
// Requester-side byte handshake bundle for the FT2232H TX arbiter.
// Three requesters share one bus; bit/byte lane i belongs to requester i.
interface ft_req_if;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );
endinterface

// File: rtl/ft_tx_arbiter.sv
// Round-robin arbiter feeding three byte streams into the FT2232H sync FIFO TX port,
// with packet lock, burst-length cap and a single-byte holding register.
module ft_tx_arbiter #(
  parameter int MAX_BURST = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        txe,
  output logic        wr,
  output logic [7:0]  data_out,
  ft_req_if.slave     req,
  output logic        grant_valid,
  output logic [1:0]  grant_id,
  output logic [15:0] tx_count
);

  localparam int         DATA_W     = 8;
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   hold_data_p0;
  logic                hold_vld_p0;
  logic [7:0]          burst;
  logic [1:0]          last_grant;

  logic                consume;
  logic                ready_sel;
  logic                load;
  logic                burst_end;
  logic                g_valid;
  logic                g_last;
  logic [DATA_W-1:0]   g_data;

  // Search order after the previous owner: last+1, last+2, then last itself.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] v);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (v[c1])      rr_pick = c1;
    else if (v[c2]) rr_pick = c2;
    else            rr_pick = last;
  endfunction

  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_last  = 1'b0;
    case (grant_id)
      2'd0: begin
        g_valid = req.req_valid[0];
        g_data  = req.req_data[7:0];
        g_last  = req.req_last[0];
      end
      2'd1: begin
        g_valid = req.req_valid[1];
        g_data  = req.req_data[15:8];
        g_last  = req.req_last[1];
      end
      2'd2: begin
        g_valid = req.req_valid[2];
        g_data  = req.req_data[23:16];
        g_last  = req.req_last[2];
      end
      default: ;
    endcase
  end

  // Reset masks the write strobe so a byte caught in the holding register is dropped, not sent.
  assign consume   = hold_vld_p0 & ~txe & ~reset;
  assign wr        = ~consume;
  assign data_out  = hold_data_p0;

  assign ready_sel = (state == XFER) && !reset && (!hold_vld_p0 || consume);
  assign req.req_ready = ready_sel ? (3'b001 << grant_id) : 3'b000;
  assign load      = ready_sel && g_valid;
  assign burst_end = g_last || (burst == BURST_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hold_data_p0 <= '0;
      hold_vld_p0  <= 1'b0;
      burst        <= '0;
      last_grant   <= 2'd2;
      tx_count     <= '0;
      grant_valid  <= 1'b0;
      grant_id     <= 2'd0;
    end else begin
      if (consume) tx_count <= tx_count + 16'd1;

      case (state)
        IDLE: begin
          if (req.req_valid != 3'b000) begin
            state       <= XFER;
            grant_id    <= rr_pick(last_grant, req.req_valid);
            grant_valid <= 1'b1;
            burst       <= '0;
          end
        end

        XFER: begin
          if (load) begin
            hold_data_p0 <= g_data;
            hold_vld_p0  <= 1'b1;
            burst        <= burst + 8'd1;
            if (burst_end) state <= DRAIN;
          end else if (consume) begin
            hold_vld_p0 <= 1'b0;
          end
        end

        DRAIN: begin
          if (consume) begin
            hold_vld_p0 <= 1'b0;
            state       <= IDLE;
            grant_valid <= 1'b0;
            last_grant  <= grant_id;
          end
        end

        default: begin
          state       <= IDLE;
          hold_vld_p0 <= 1'b0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ft_tx_arbiter.md
FT_TX_ARBITER -- requirements
Module: ft_tx_arbiter

Interface
REQ-001 Parameter: MAX_BURST, 64, max bytes per grant before forced rotation (legal 2..255).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 txe  input  1  FT2232H TXE#, active low; low = chip FIFO can take a byte.
REQ-005 wr  output  1  FT2232H WR#, active low.
REQ-006 data_out  output  8  byte driven to FT2232H data bus.
REQ-007 req_valid  input  3  per-requester byte valid; bit i = requester i.
REQ-008 req_data  input  24  requester i byte on bits [8i+7:8i].
REQ-009 req_last  input  3  per-requester end-of-packet marker, qualified by req_valid.
REQ-010 req_ready  output  3  per-requester byte accepted this cycle.
REQ-011 grant_valid  output  1  a requester currently owns the TX path.
REQ-012 grant_id  output  2  index of owning requester (0..2); meaningful only when grant_valid=1.
REQ-013 tx_count  output  16  total bytes written to FT2232H since reset, wraps modulo 2^16.

Function
REQ-014 States SHALL be IDLE, XFER, DRAIN, held in a registered state variable.
REQ-015 Holding register: 8-bit data register plus hold_valid flag; data_out SHALL always drive the data register.
REQ-016 wr SHALL be combinational: wr = 0 iff hold_valid=1 and txe=0, else 1.
REQ-017 A byte is consumed at a rising edge where wr=0 (equivalently hold_valid=1 and txe=0); tx_count SHALL increment by 1 on each consume.
REQ-018 txe high SHALL never cause data loss: hold register and data_out stay unchanged until a consume occurs.
REQ-019 IDLE: if req_valid != 0, select requester by round-robin, starting the search at (last_grant+1) mod 3, then (last_grant+2) mod 3, then last_grant; go to XFER; latch grant_id; clear burst counter.
REQ-020 IDLE with req_valid=0: stay in IDLE, grant_valid=0, req_ready=0.
REQ-021 grant_valid SHALL be 1 in XFER and DRAIN, 0 in IDLE.
REQ-022 XFER: req_ready[grant_id] = (hold_valid=0 or consume this cycle); all other req_ready bits SHALL be 0.
REQ-023 Load = req_valid[grant_id] and req_ready[grant_id]; on load, the hold register takes the granted byte, hold_valid=1, burst counter +1.
REQ-024 Consume without same-cycle load: hold_valid cleared; with same-cycle load: hold_valid stays 1 (back-to-back, one byte per clock).
REQ-025 XFER -> DRAIN on a load where req_last=1 or the burst counter equals MAX_BURST-1 before increment.
REQ-026 XFER: if the granted requester drops req_valid, the grant SHALL be retained (packet lock) and wr goes high once the hold register empties.
REQ-027 DRAIN: req_ready=0; on consume -> IDLE, last_grant := grant_id.
REQ-028 In IDLE, hold_valid SHALL be 0, so wr=1.
REQ-029 last_grant is updated only on DRAIN exit; a burst truncated by MAX_BURST rotates priority exactly like a req_last end.

Reset
REQ-030 Reset SHALL force state=IDLE, hold_valid=0, data register=0x00, burst counter=0, last_grant=2 (so requester 0 wins first), tx_count=0.
REQ-031 During and one cycle after reset: wr=1, data_out=0x00, req_ready=0, grant_valid=0, grant_id=0.
REQ-032 Reset mid-XFER or mid-DRAIN SHALL discard any held byte without writing it; a reset edge with wr=0 is not counted.

Verification
REQ-033 Single packet: req0 sends 0x10,0x11,0x12 (last on 0x12), txe=0 -> wr low 3 consecutive cycles, data_out 0x10,0x11,0x12, tx_count=3, return to IDLE.
REQ-034 Round-robin: req0, req1, req2 all hold 2-byte packets -> grant order 0,1,2, then 0 again if req0 still valid; grant_id matches the data source.
REQ-035 Backpressure: txe high for 5 cycles after the first byte 0xA5 loads -> wr=1, data_out held at 0xA5, req_ready=0; txe low -> 0xA5 written once, no duplicate or lost byte.
REQ-036 Burst cap: MAX_BURST=4, req1 streams 10 bytes with no last, req2 waiting -> req1 sends 4, req2 granted next, req1 resumes after req2.
REQ-037 Requester stall: req0 drops valid after 2 bytes for 3 cycles -> grant held, wr=1 during gap, resumes with byte 3, no other grant.
REQ-038 Reset mid-packet: assert reset with hold_valid=1 -> next cycle wr=1, tx_count=0, grant_valid=0; first grant after reset goes to requester 0.
